// File: rtl/wishbone_data_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wishbone_data_master                                                       |
// | MEM-stage load/store to single-beat Wishbone classic initiator.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wishbone_data_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MEM_REQ_VALID,
   input  logic        MEM_KILL,
   input  logic        MEM_WE,
   input  logic [31:0] MEM_ADDR,
   input  logic [31:0] MEM_WDATA,
   input  logic [1:0]  MEM_SIZE,
   input  logic        MEM_UNSIGNED,
   output logic        WISHBONE_REQ,
   output logic        WISHBONE_DONE,
   output logic [31:0] LOAD_RDATA,
   output logic        BUS_ERR,
   output logic        WB_CYC_O,
   output logic        WB_STB_O,
   output logic        WB_WE_O,
   output logic [31:0] WB_ADR_O,
   output logic [31:0] WB_DAT_O,
   output logic [3:0]  WB_SEL_O,
   input  logic [31:0] WB_DAT_I,
   input  logic        WB_ACK_I,
   input  logic        WB_ERR_I
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int C_TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] C_TO_LAST = C_TO_LAST_I[CW-1:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic [3:0]    sel_q, sel_d;
   logic [1:0]    size_q, size_d;
   logic [1:0]    lane_q, lane_d;
   logic          uns_q, uns_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          w_misaligned;
   logic [3:0]    w_sel;
   logic [31:0]   w_dat;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;

   always_comb begin
      w_misaligned = 1'b0;
      w_sel        = 4'b1111;
      w_dat        = MEM_WDATA;
      case (MEM_SIZE)
         2'd0: begin
            w_sel = 4'b0001 << MEM_ADDR[1:0];
            w_dat = {4{MEM_WDATA[7:0]}};
         end
         2'd1: begin
            w_misaligned = MEM_ADDR[0];
            w_sel        = MEM_ADDR[1] ? 4'b1100 : 4'b0011;
            w_dat        = {2{MEM_WDATA[15:0]}};
         end
         2'd2:    w_misaligned = |MEM_ADDR[1:0];
         default: w_misaligned = 1'b1;
      endcase
   end

   // Load lane extraction uses the attributes latched at issue, not the live MEM inputs.
   always_comb begin
      case (lane_q)
         2'd0:    w_byte = WB_DAT_I[7:0];
         2'd1:    w_byte = WB_DAT_I[15:8];
         2'd2:    w_byte = WB_DAT_I[23:16];
         default: w_byte = WB_DAT_I[31:24];
      endcase
      w_half = lane_q[1] ? WB_DAT_I[31:16] : WB_DAT_I[15:0];
      case (size_q)
         2'd0:    w_load = {{24{~uns_q & w_byte[7]}}, w_byte};
         2'd1:    w_load = {{16{~uns_q & w_half[15]}}, w_half};
         default: w_load = WB_DAT_I;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      size_d  = size_q;
      lane_d  = lane_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (MEM_REQ_VALID && !MEM_KILL) begin
               rdata_d = '0;
               if (w_misaligned) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  cyc_d   = 1'b1;
                  we_d    = MEM_WE;
                  adr_d   = {MEM_ADDR[31:2], 2'b00};
                  dat_d   = w_dat;
                  sel_d   = w_sel;
                  size_d  = MEM_SIZE;
                  lane_d  = MEM_ADDR[1:0];
                  uns_d   = MEM_UNSIGNED;
                  cnt_d   = '0;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            if (WB_ERR_I) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else if (WB_ACK_I) begin
               cyc_d   = 1'b0;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'h0 : w_load;
               state_d = S_DONE;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == C_TO_LAST)) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         size_q  <= '0;
         lane_q  <= '0;
         uns_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         uns_q   <= uns_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign WISHBONE_REQ  = (state_q != S_IDLE) | (MEM_REQ_VALID & ~MEM_KILL);
   assign WISHBONE_DONE = (state_q == S_DONE);
   assign LOAD_RDATA    = rdata_q;
   assign BUS_ERR       = err_q;
   assign WB_CYC_O      = cyc_q;
   assign WB_STB_O      = cyc_q;
   assign WB_WE_O       = we_q;
   assign WB_ADR_O      = adr_q;
   assign WB_DAT_O      = dat_q;
   assign WB_SEL_O      = sel_q;

endmodule
`default_nettype wire
